hall_call_arbiter: RTL and testbench
====================================

# hall_call_arbiter

Parametrised hall-call register and target selector for the elevator controller, replacing the fixed four-floor combinational button decoder. Latches up/down hall-button presses per floor into pending-call lamps, clears them when the car reports service, and each cycle presents one registered target call chosen by a direction-preserving sweep (LOOK) order. Sits between the debounced hall-button inputs and the car motion/door controller.

## Interface
- FLOORS, 4, number of floors (2..16); floor 0 is the lowest.
- FW, 2, width of floor indices; must satisfy 2**FW >= FLOORS.

- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active-low; sampled on rising edge of clk.
- up_btn  input  FLOORS  level up-call request per floor; bit FLOORS-1 ignored.
- down_btn  input  FLOORS  level down-call request per floor; bit 0 ignored.
- cur_floor  input  FW  floor the car is at or passing.
- car_dir  input  1  current sweep direction, 1 = up, 0 = down.
- serve  input  1  one-cycle pulse: car doors opening at cur_floor.
- serve_up  input  1  direction being served with serve (1 = up call, 0 = down call).
- up_pend  output  FLOORS  registered pending up calls (lamp drive).
- down_pend  output  FLOORS  registered pending down calls (lamp drive).
- call_valid  output  1  registered; a target call exists.
- call_floor  output  FW  registered target floor; 0 when call_valid = 0.
- call_up  output  1  registered target direction; 0 when call_valid = 0.

## Operation
- Pending registers, per floor f, each cycle:
  - clear if serve = 1, cur_floor = f, and serve_up selects that register;
  - else set if corresponding button bit is 1;
  - else hold.
- Clear beats set in the same cycle; a button still held the next cycle re-latches.
- up_pend[FLOORS-1] and down_pend[0] are constant 0.
- cur_floor >= FLOORS (out of range): serve clears nothing; call_valid forced 0 next cycle; pending registers still latch presses.
- Target selection (combinational search over the registered pending bits, result registered):
  - car_dir = 1: up_pend ascending cur_floor..FLOORS-1; then down_pend descending FLOORS-1..0; then up_pend ascending 0..cur_floor-1.
  - car_dir = 0: down_pend descending cur_floor..0; then up_pend ascending 0..FLOORS-1; then down_pend descending FLOORS-1..cur_floor+1.
  - The first set bit found gives call_floor. call_up = 1 if that bit came from up_pend.
  - No set bit: call_valid = 0, call_floor = 0, call_up = 0.
- The block never changes car_dir. Direction reversal is the motion controller's decision, made from call_up and call_floor.

## Timing
- Reset (rst_n = 0 at an edge): up_pend, down_pend, call_valid, call_floor and call_up all become 0 at that edge; inputs are ignored.
- Reset asserted mid-operation discards every pending call; presses resume latching on the first edge after rst_n returns to 1.
- Button high at edge n: the pend bit is 1 after edge n. The call_* outputs reflect it after edge n+1 (2-cycle press-to-target latency).
- serve at edge n: the bit clears after edge n. The call_* outputs retarget after edge n+1.
- Changes to cur_floor or car_dir affect call_* one edge later.
- No handshake on call_*; the consumer samples them every cycle. Outputs are glitch-free registers.

## Test plan
- Reset: hold rst_n = 0 with all buttons high for 2 cycles -> every output 0. Release with buttons low -> outputs stay 0.
- Latch and serve, FLOORS = 4: pulse up_btn[1] for one cycle; cur_floor = 0, car_dir = 1 -> up_pend = 4'b0010 next cycle; call_valid = 1, call_floor = 1, call_up = 1 the cycle after. Then serve with serve_up = 1 at cur_floor = 1 -> up_pend = 0, and call_valid = 0 one cycle later.
- Sweep order, FLOORS = 8: pending up[2], up[6], down[5]; cur_floor = 3, car_dir = 1 -> target 6/up. Clear up[6] -> target 5/down. Clear down[5] -> target 2/up.
- Clear-vs-set collision: up_btn[2] held high while serve/serve_up = 1 at cur_floor = 2 -> bit reads 0 for one cycle, then 1 again.
- Ignored bits and out-of-range floor: down_btn[0] and up_btn[FLOORS-1] high -> pend bits stay 0. Set cur_floor = 7 with FLOORS = 5 and calls pending -> call_valid = 0, pend bits unchanged.
- Down sweep, FLOORS = 16, FW = 4: down[9] and up[12] pending; cur_floor = 10, car_dir = 0 -> target 9/down. Clear down[9] -> target 12/up.

Source files
------------

// File: rtl/hall_call_if.sv
// hall_call_if: hall-button inputs, car status and pending/target outputs of the hall-call arbiter
interface hall_call_if #(
  parameter int FLOORS = 4,
  parameter int FW = 2
);
  logic [FLOORS-1:0] up_btn;
  logic [FLOORS-1:0] down_btn;
  logic [FW-1:0] cur_floor;
  logic car_dir;
  logic serve;
  logic serve_up;
  logic [FLOORS-1:0] up_pend;
  logic [FLOORS-1:0] down_pend;
  logic call_valid;
  logic [FW-1:0] call_floor;
  logic call_up;
  modport master (
    output up_btn, down_btn, cur_floor, car_dir, serve, serve_up,
    input up_pend, down_pend, call_valid, call_floor, call_up
  );
  modport slave (
    input up_btn, down_btn, cur_floor, car_dir, serve, serve_up,
    output up_pend, down_pend, call_valid, call_floor, call_up
  );
endinterface

// File: rtl/hall_call_arbiter.sv
// hall_call_arbiter: latches hall calls into lamps and registers one LOOK-order target per cycle
module hall_call_arbiter #(
  parameter int FLOORS = 4,
  parameter int FW = 2
) (
  input logic clk,
  input logic rst_n,
  hall_call_if.slave bus
);
  localparam logic [FLOORS-1:0] UP_MSK = {1'b0, {(FLOORS-1){1'b1}}};
  localparam logic [FLOORS-1:0] DN_MSK = {{(FLOORS-1){1'b1}}, 1'b0};
  logic [FLOORS-1:0] up_q, up_d, down_q, down_d, cur_oh;
  logic [FW-1:0] call_floor_q, call_floor_d, sel_floor;
  logic call_valid_q, call_valid_d, call_up_q, call_up_d, found, sel_up, in_range;
  int cur;
  always_comb begin
    // an out-of-range floor shifts the one-hot off the top, so serve clears nothing
    cur_oh = FLOORS'(1) << bus.cur_floor;
    in_range = {1'b0, bus.cur_floor} < (FW+1)'(FLOORS);
    cur = int'(bus.cur_floor);
    up_d = (up_q | bus.up_btn) & ~((bus.serve && bus.serve_up) ? cur_oh : '0) & UP_MSK;
    down_d = (down_q | bus.down_btn) & ~((bus.serve && !bus.serve_up) ? cur_oh : '0) & DN_MSK;
    found = 1'b0;
    sel_floor = '0;
    sel_up = 1'b0;
    if (bus.car_dir) begin
      for (int f = 0; f < FLOORS; f++)
        if (!found && up_q[f] && f >= cur) begin found = 1'b1; sel_floor = FW'(f); sel_up = 1'b1; end
      for (int f = FLOORS - 1; f >= 0; f--)
        if (!found && down_q[f]) begin found = 1'b1; sel_floor = FW'(f); end
      for (int f = 0; f < FLOORS; f++)
        if (!found && up_q[f] && f < cur) begin found = 1'b1; sel_floor = FW'(f); sel_up = 1'b1; end
    end else begin
      for (int f = FLOORS - 1; f >= 0; f--)
        if (!found && down_q[f] && f <= cur) begin found = 1'b1; sel_floor = FW'(f); end
      for (int f = 0; f < FLOORS; f++)
        if (!found && up_q[f]) begin found = 1'b1; sel_floor = FW'(f); sel_up = 1'b1; end
      for (int f = FLOORS - 1; f >= 0; f--)
        if (!found && down_q[f] && f > cur) begin found = 1'b1; sel_floor = FW'(f); end
    end
    call_valid_d = found && in_range;
    call_floor_d = call_valid_d ? sel_floor : '0;
    call_up_d = call_valid_d && sel_up;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      up_q <= '0;
      down_q <= '0;
      call_valid_q <= 1'b0;
      call_floor_q <= '0;
      call_up_q <= 1'b0;
    end else begin
      up_q <= up_d;
      down_q <= down_d;
      call_valid_q <= call_valid_d;
      call_floor_q <= call_floor_d;
      call_up_q <= call_up_d;
    end
  end
  assign bus.up_pend = up_q;
  assign bus.down_pend = down_q;
  assign bus.call_valid = call_valid_q;
  assign bus.call_floor = call_floor_q;
  assign bus.call_up = call_up_q;
endmodule

// File: tb/tb_hall_call_arbiter.sv
// tb_hall_call_arbiter: directed checks of latching, serving, LOOK order and reset over four floor counts
module tb_hall_call_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  hall_call_if #(4, 2) b4();
  hall_call_if #(8, 3) b8();
  hall_call_if #(5, 3) b5();
  hall_call_if #(16, 4) b16();
  hall_call_arbiter #(.FLOORS(4), .FW(2)) d4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  hall_call_arbiter #(.FLOORS(8), .FW(3)) d8 (.clk(clk), .rst_n(rst_n), .bus(b8));
  hall_call_arbiter #(.FLOORS(5), .FW(3)) d5 (.clk(clk), .rst_n(rst_n), .bus(b5));
  hall_call_arbiter #(.FLOORS(16), .FW(4)) d16 (.clk(clk), .rst_n(rst_n), .bus(b16));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic call4(input string tag, input logic v, input logic [31:0] f, input logic u);
    check({tag, ".v"}, 32'(b4.call_valid), 32'(v));
    check({tag, ".f"}, 32'(b4.call_floor), f);
    check({tag, ".u"}, 32'(b4.call_up), 32'(u));
  endtask
  task automatic call8(input string tag, input logic v, input logic [31:0] f, input logic u);
    check({tag, ".v"}, 32'(b8.call_valid), 32'(v));
    check({tag, ".f"}, 32'(b8.call_floor), f);
    check({tag, ".u"}, 32'(b8.call_up), 32'(u));
  endtask
  task automatic call5(input string tag, input logic v, input logic [31:0] f, input logic u);
    check({tag, ".v"}, 32'(b5.call_valid), 32'(v));
    check({tag, ".f"}, 32'(b5.call_floor), f);
    check({tag, ".u"}, 32'(b5.call_up), 32'(u));
  endtask
  task automatic call16(input string tag, input logic v, input logic [31:0] f, input logic u);
    check({tag, ".v"}, 32'(b16.call_valid), 32'(v));
    check({tag, ".f"}, 32'(b16.call_floor), f);
    check({tag, ".u"}, 32'(b16.call_up), 32'(u));
  endtask
  initial begin
    b4.up_btn = '1; b4.down_btn = '1; b4.cur_floor = '0; b4.car_dir = 1'b1; b4.serve = 1'b0; b4.serve_up = 1'b0;
    b8.up_btn = '1; b8.down_btn = '1; b8.cur_floor = '0; b8.car_dir = 1'b1; b8.serve = 1'b0; b8.serve_up = 1'b0;
    b5.up_btn = '1; b5.down_btn = '1; b5.cur_floor = '0; b5.car_dir = 1'b1; b5.serve = 1'b0; b5.serve_up = 1'b0;
    b16.up_btn = '1; b16.down_btn = '1; b16.cur_floor = '0; b16.car_dir = 1'b1; b16.serve = 1'b0; b16.serve_up = 1'b0;
    @(negedge clk);
    step();
    step();
    check("rst.up4", 32'(b4.up_pend), 0);
    check("rst.dn4", 32'(b4.down_pend), 0);
    call4("rst4", 1'b0, 0, 1'b0);
    check("rst.up16", 32'(b16.up_pend), 0);
    check("rst.dn16", 32'(b16.down_pend), 0);
    call16("rst16", 1'b0, 0, 1'b0);
    rst_n = 1'b1;
    b4.up_btn = '0; b4.down_btn = '0; b8.up_btn = '0; b8.down_btn = '0;
    b5.up_btn = '0; b5.down_btn = '0; b16.up_btn = '0; b16.down_btn = '0;
    step();
    step();
    check("idle.up8", 32'(b8.up_pend), 0);
    check("idle.dn8", 32'(b8.down_pend), 0);
    call8("idle8", 1'b0, 0, 1'b0);
    // press-to-target latency and serve on four floors
    b4.up_btn = 4'b0010;
    step();
    b4.up_btn = '0;
    check("latch.up4", 32'(b4.up_pend), 32'h2);
    call4("latch.early", 1'b0, 0, 1'b0);
    step();
    call4("latch.tgt", 1'b1, 1, 1'b1);
    b4.cur_floor = 2'd1; b4.serve = 1'b1; b4.serve_up = 1'b1;
    step();
    b4.serve = 1'b0;
    check("serve.up4", 32'(b4.up_pend), 0);
    call4("serve.lag", 1'b1, 1, 1'b1);
    step();
    call4("serve.idle", 1'b0, 0, 1'b0);
    // serve in the other direction must not touch the up lamp
    b4.cur_floor = 2'd2; b4.up_btn = 4'b0100;
    step();
    b4.up_btn = '0; b4.serve = 1'b1; b4.serve_up = 1'b0;
    step();
    b4.serve = 1'b0;
    check("wrongdir.up4", 32'(b4.up_pend), 32'h4);
    // clear beats a held button, which then re-latches
    b4.up_btn = 4'b0100; b4.serve = 1'b1; b4.serve_up = 1'b1;
    step();
    b4.serve = 1'b0;
    check("coll.clr", 32'(b4.up_pend), 0);
    step();
    check("coll.relatch", 32'(b4.up_pend), 32'h4);
    b4.up_btn = '0; b4.serve = 1'b1;
    step();
    b4.serve = 1'b0;
    b4.up_btn = 4'b1000; b4.down_btn = 4'b0001;
    step();
    b4.up_btn = '0; b4.down_btn = '0;
    check("ign.up4", 32'(b4.up_pend), 0);
    check("ign.dn4", 32'(b4.down_pend), 0);
    // LOOK order on eight floors, upward sweep from 3
    b8.cur_floor = 3'd3; b8.car_dir = 1'b1; b8.up_btn = 8'b0100_0100; b8.down_btn = 8'b0010_0000;
    step();
    b8.up_btn = '0; b8.down_btn = '0;
    step();
    call8("sweep.a", 1'b1, 6, 1'b1);
    b8.cur_floor = 3'd6; b8.serve = 1'b1; b8.serve_up = 1'b1;
    step();
    b8.cur_floor = 3'd3; b8.serve = 1'b0;
    step();
    call8("sweep.b", 1'b1, 5, 1'b0);
    b8.cur_floor = 3'd5; b8.serve = 1'b1; b8.serve_up = 1'b0;
    step();
    b8.cur_floor = 3'd3; b8.serve = 1'b0;
    step();
    call8("sweep.c", 1'b1, 2, 1'b1);
    // out-of-range floor on five floors: no clear, no target, presses still latch
    b5.cur_floor = 3'd0; b5.car_dir = 1'b1; b5.up_btn = 5'b10010; b5.down_btn = 5'b00001;
    step();
    b5.up_btn = '0; b5.down_btn = '0;
    step();
    check("oor.ign", 32'(b5.up_pend), 32'h2);
    call5("oor.pre", 1'b1, 1, 1'b1);
    b5.cur_floor = 3'd7; b5.serve = 1'b1; b5.serve_up = 1'b1; b5.down_btn = 5'b01000;
    step();
    b5.serve = 1'b0; b5.down_btn = '0;
    check("oor.up", 32'(b5.up_pend), 32'h2);
    check("oor.dn", 32'(b5.down_pend), 32'h8);
    step();
    call5("oor.tgt", 1'b0, 0, 1'b0);
    b5.cur_floor = 3'd1;
    step();
    call5("oor.back", 1'b1, 1, 1'b1);
    // downward sweep on sixteen floors from 10
    b16.cur_floor = 4'd10; b16.car_dir = 1'b0; b16.down_btn = 16'h0200; b16.up_btn = 16'h1000;
    step();
    b16.down_btn = '0; b16.up_btn = '0;
    step();
    call16("down.a", 1'b1, 9, 1'b0);
    b16.cur_floor = 4'd9; b16.serve = 1'b1; b16.serve_up = 1'b0;
    step();
    b16.cur_floor = 4'd10; b16.serve = 1'b0;
    step();
    call16("down.b", 1'b1, 12, 1'b1);
    // reset mid-operation drops calls; presses resume on the first edge after release
    rst_n = 1'b0;
    step();
    check("mrst.up16", 32'(b16.up_pend), 0);
    call16("mrst16", 1'b0, 0, 1'b0);
    check("mrst.up5", 32'(b5.up_pend), 0);
    rst_n = 1'b1; b16.up_btn = 16'h0008;
    step();
    b16.up_btn = '0;
    check("mrst.relatch", 32'(b16.up_pend), 32'h8);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
